// File: rtl/fifo_stream_gen.sv
// ============================================================================
// Module   : fifo_stream_gen
// Brief    : FX3 slave-FIFO write master streaming selectable test patterns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_gen #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 1024,
    parameter int CNT_W     = 32,
    parameter int LED_W     = 8
) (
    input  logic                             PCLK,
    input  logic                             RESET_n,
    input  logic                             EN,
    input  logic [1:0]                       MODE,
    input  logic                             FULL_n,
    output logic                             WR_n,
    output logic                             PKTEND_n,
    output logic [DATA_W-1:0]                DQ,
    output logic [LED_W-1:0]                 LED,
    output logic [$clog2(BURST_LEN+1)-1:0]   BURST_CNT
);

    localparam int             BC_W   = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0] C_LAST = BC_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_WRITE    = 2'd2,
        S_PKTEND   = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_pat;
    logic [BC_W-1:0]     r_burst_cnt;
    logic [CNT_W-1:0]    r_tot;
    logic                r_wr_n;
    logic                r_pktend_n;

    logic [DATA_W-1:0]   w_alt_seed;
    logic [DATA_W-1:0]   w_seed;
    logic [DATA_W-1:0]   w_pat_next;

    // Alternating seed: odd bit positions set (0xAA.. pattern)
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_alt_seed
        assign w_alt_seed[gi] = 1'(gi % 2);
    end

    always_comb begin
        w_seed = '0;
        case (MODE)
            2'd0:    w_seed = '0;
            2'd1:    w_seed = '1;
            2'd2:    w_seed = DATA_W'(1);
            default: w_seed = w_alt_seed;
        endcase
    end

    always_comb begin
        w_pat_next = r_pat;
        case (r_mode)
            2'd0:    w_pat_next = r_pat + DATA_W'(1);
            2'd1:    w_pat_next = r_pat - DATA_W'(1);
            2'd2:    w_pat_next = {r_pat[DATA_W-2:0], r_pat[DATA_W-1]};
            default: w_pat_next = ~r_pat;
        endcase
    end

    // All state launches on the falling edge so the FX3 gets half a cycle of setup
    always_ff @(negedge PCLK) begin
        if (!RESET_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_pat       <= '0;
            r_burst_cnt <= '0;
            r_tot       <= '0;
            r_wr_n      <= 1'b1;
            r_pktend_n  <= 1'b1;
        end else begin
            // A low strobe during the elapsed cycle means the FX3 took a word
            if (!r_wr_n) begin
                r_pat <= w_pat_next;
                r_tot <= r_tot + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (EN) begin
                        r_state <= S_WAIT_RDY;
                        r_mode  <= MODE;
                        r_pat   <= w_seed;
                    end
                end
                S_WAIT_RDY: begin
                    if (!EN) begin
                        if (r_burst_cnt != '0) begin
                            r_state    <= S_PKTEND;
                            r_pktend_n <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (FULL_n) begin
                        r_state <= S_WRITE;
                        r_wr_n  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (r_burst_cnt == C_LAST) begin
                        // Full buffer commits by itself on the FX3 side
                        r_wr_n      <= 1'b1;
                        r_burst_cnt <= '0;
                        r_state     <= S_WAIT_RDY;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + BC_W'(1);
                        if (!EN) begin
                            r_wr_n     <= 1'b1;
                            r_pktend_n <= 1'b0;
                            r_state    <= S_PKTEND;
                        end else if (!FULL_n) begin
                            r_wr_n  <= 1'b1;
                            r_state <= S_WAIT_RDY;
                        end
                    end
                end
                default: begin
                    r_pktend_n  <= 1'b1;
                    r_burst_cnt <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign WR_n      = r_wr_n;
    assign PKTEND_n  = r_pktend_n;
    assign DQ        = r_pat;
    assign BURST_CNT = r_burst_cnt;
    assign LED       = ~r_tot[CNT_W-1 -: LED_W];

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_gen.sv
// ============================================================================
// Module   : tb_fifo_stream_gen
// Brief    : Scoreboard bench for fifo_stream_gen (8-bit data, 16-word bursts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_gen;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 16;
    localparam int CNT_W     = 12;
    localparam int LED_W     = 4;

    logic        PCLK;
    logic        RESET_n;
    logic        EN;
    logic [1:0]  MODE;
    logic        FULL_n;
    logic        WR_n;
    logic        PKTEND_n;
    logic [7:0]  DQ;
    logic [3:0]  LED;
    logic [4:0]  BURST_CNT;

    fifo_stream_gen #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W),
        .LED_W     (LED_W)
    ) dut (
        .PCLK      (PCLK),
        .RESET_n   (RESET_n),
        .EN        (EN),
        .MODE      (MODE),
        .FULL_n    (FULL_n),
        .WR_n      (WR_n),
        .PKTEND_n  (PKTEND_n),
        .DQ        (DQ),
        .LED       (LED),
        .BURST_CNT (BURST_CNT)
    );

    initial PCLK = 1'b1;
    always #5 PCLK = ~PCLK;

    typedef struct {
        bit         pkt;
        logic [7:0] dq;
        logic [4:0] bc;
        logic [3:0] led;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          cap_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;
    logic [11:0] tot_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pattern: i-th word of a stream started in mode m
    function automatic logic [7:0] pat(input logic [1:0] m, input int i);
        case (m)
            2'd0:    return 8'(i % 256);
            2'd1:    return 8'(255 - (i % 256));
            2'd2:    return 8'(1 << (i % 8));
            default: return ((i % 2) == 0) ? 8'hAA : 8'h55;
        endcase
    endfunction

    // Monitor: the FX3 side captures on the rising edge
    always @(posedge PCLK) begin
        if (mon_en && (WR_n === 1'b0 || PKTEND_n === 1'b0)) begin
            if (WR_n === 1'b0)
                chk("pktend_with_wr", 32'(PKTEND_n), 32'd1);
            if (sbq.size() == 0) begin
                chk("unexpected_event", {30'd0, WR_n, PKTEND_n}, 32'd3);
            end else begin
                mon_e = sbq.pop_front();
                chk("event_kind", 32'(WR_n), 32'(mon_e.pkt));
                if (!mon_e.pkt)
                    chk("dq", 32'(DQ), 32'(mon_e.dq));
                chk("burst_cnt", 32'(BURST_CNT), 32'(mon_e.bc));
                chk("led", 32'(LED), 32'(mon_e.led));
            end
        end
    end

    task automatic run_session(input logic [1:0] m, input int k, input int full_pct,
                               input int bp_at, input bit do_reset, input bit chk_start);
        exp_t e;
        int   cnt, rel, bp_left, budget;
        bit   bp_done;
        for (int i = 0; i < k; i++) begin
            e.pkt = 0; e.dq = pat(m, i); e.bc = 5'(i % BURST_LEN); e.led = ~tot_model[11:8];
            sbq.push_back(e);
            tot_model++;
        end
        if (!do_reset && (k % BURST_LEN) != 0) begin
            e.pkt = 1; e.dq = 8'h00; e.bc = 5'(k % BURST_LEN); e.led = ~tot_model[11:8];
            sbq.push_back(e);
        end
        cap_q.delete();
        cnt = 0; rel = 0; bp_left = 0; bp_done = 0;
        budget = 40 * k + 64;
        MODE = m;
        EN   = 1'b1;
        FULL_n = chk_start ? 1'b1 : ($urandom_range(99) < full_pct);
        while (cnt < k && rel < budget) begin
            @(posedge PCLK);
            rel++;
            if (WR_n === 1'b0) begin
                cnt++;
                cap_q.push_back(rel);
            end
            if (cnt < k) begin
                #1;
                MODE = 2'($urandom_range(3));
                if (bp_left > 0) begin
                    FULL_n = 1'b0;
                    bp_left--;
                end else if (bp_at > 0 && cnt == bp_at && !bp_done) begin
                    FULL_n  = 1'b0;
                    bp_left = 2;
                    bp_done = 1;
                end else begin
                    FULL_n = ($urandom_range(99) < full_pct);
                end
            end
        end
        chk("session_words", 32'(cnt), 32'(k));
        if (chk_start && cap_q.size() > 0)
            chk("start_latency", 32'(cap_q[0]), 32'd2);
        #1;
        if (do_reset) begin
            RESET_n = 1'b0;
            EN      = 1'b0;
            FULL_n  = 1'b1;
            @(posedge PCLK);
            chk("rst_wr_n", 32'(WR_n), 32'd1);
            chk("rst_pktend_n", 32'(PKTEND_n), 32'd1);
            chk("rst_dq", 32'(DQ), 32'd0);
            chk("rst_burst_cnt", 32'(BURST_CNT), 32'd0);
            chk("rst_led", 32'(LED), 32'hF);
            #1;
            RESET_n   = 1'b1;
            tot_model = '0;
        end else begin
            EN     = 1'b0;
            FULL_n = 1'b1;
        end
        repeat (6) @(posedge PCLK);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("end_burst_cnt", 32'(BURST_CNT), 32'd0);
        chk("end_wr_n", 32'(WR_n), 32'd1);
        sbq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, k;
        RESET_n = 1'b0;
        EN      = 1'b0;
        MODE    = 2'd0;
        FULL_n  = 1'b1;
        repeat (3) @(posedge PCLK);
        chk("init_wr_n", 32'(WR_n), 32'd1);
        chk("init_pktend_n", 32'(PKTEND_n), 32'd1);
        chk("init_dq", 32'(DQ), 32'd0);
        chk("init_burst_cnt", 32'(BURST_CNT), 32'd0);
        chk("init_led", 32'(LED), 32'hF);
        #1;
        RESET_n = 1'b1;
        mon_en  = 1;
        repeat (2) @(posedge PCLK);
        #1;

        // Two back-to-back full bursts: 16 words, one idle cycle, 16 words
        run_session(2'd0, 32, 100, 0, 0, 1);
        chk("burst_gap", 32'(cap_q[16] - cap_q[15]), 32'd2);
        chk("burst_span", 32'(cap_q[31] - cap_q[0]), 32'd32);

        // FULL_n low for three cycles after word 5
        run_session(2'd0, 12, 100, 6, 0, 1);
        chk("bp_before", 32'(cap_q[5] - cap_q[4]), 32'd1);
        chk("bp_resume", 32'(cap_q[6] - cap_q[5]), 32'd4);

        run_session(2'd0, 7, 100, 0, 0, 1);
        run_session(2'd1, 20, 100, 0, 0, 1);
        run_session(2'd2, 17, 100, 0, 0, 1);
        run_session(2'd3, 5, 100, 0, 0, 1);
        run_session(2'd2, 9, 100, 0, 1, 1);
        run_session(2'd0, 300, 100, 0, 0, 1);

        for (int s = 0; s < 25; s++) begin
            m = int'($urandom_range(3));
            if ($urandom_range(3) == 0)
                k = BURST_LEN * int'($urandom_range(1, 3));
            else
                k = int'($urandom_range(1, 60));
            run_session(2'(m), k, 70, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
